// File: rtl/serial_parity_rx.sv
// ============================================================================
//  Module   : serial_parity_rx
//  Brief    : LSB-first serial word receiver with trailing XOR parity check.
//             Optional parity-error counter: define PARITY_ERR_COUNT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_parity_rx #(
   parameter int DATA_BITS  = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   input  logic                 sof,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_valid,
   output logic                 busy,
   output logic [7:0]           err_count
);

   localparam int CNT_W = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 acc_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 perr_q;
   logic                 perr_d;
   logic                 fv_q;
   logic                 par_take;

   // Shift register is cleared at sof, so OR-ing the new bit in is enough.
   always_comb begin
      shift_d  = shift_q | (DATA_BITS'(bit_in) << cnt_q);
      cnt_d    = cnt_q + CNT_W'(1);
      perr_d   = acc_q ^ bit_in ^ ODD_PARITY;
      par_take = bit_valid && !sof && (state_q == S_PARITY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         acc_q   <= 1'b0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         fv_q    <= 1'b0;
      end else begin
         fv_q <= 1'b0;
         if (bit_valid) begin
            if (sof) begin
               // sof restarts from any state; an interrupted frame is dropped.
               shift_q <= DATA_BITS'(bit_in);
               acc_q   <= bit_in;
               cnt_q   <= CNT_W'(1);
               state_q <= (DATA_BITS == 1) ? S_PARITY : S_DATA;
            end else begin
               case (state_q)
                  S_DATA: begin
                     shift_q <= shift_d;
                     acc_q   <= acc_q ^ bit_in;
                     cnt_q   <= cnt_d;
                     if (cnt_d == LAST_CNT) begin
                        state_q <= S_PARITY;
                     end
                  end
                  S_PARITY: begin
                     data_q  <= shift_q;
                     perr_q  <= perr_d;
                     fv_q    <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign data_out    = data_q;
   assign parity_err  = perr_q;
   assign frame_valid = fv_q;
   assign busy        = (state_q != S_IDLE);

`ifdef PARITY_ERR_COUNT_EN
   logic [7:0] errcnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         errcnt_q <= 8'd0;
      end else if (par_take && perr_d && (errcnt_q != 8'hFF)) begin
         errcnt_q <= errcnt_q + 8'd1;
      end
   end

   assign err_count = errcnt_q;
`else
   assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
// ============================================================================
//  Module   : tb_serial_parity_rx
//  Brief    : Directed scoreboard bench for serial_parity_rx (even and odd).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_parity_rx;

`ifdef PARITY_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_in;
   logic       bit_valid;
   logic       sof;
   logic [7:0] data_out;
   logic       parity_err;
   logic       frame_valid;
   logic       busy;
   logic [7:0] err_count;
   logic [7:0] o_data_out;
   logic       o_parity_err;
   logic       o_frame_valid;
   logic       o_busy;
   logic [7:0] o_err_count;

   always #5 clk = ~clk;

   serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b0)) u_even (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .data_out(data_out), .parity_err(parity_err), .frame_valid(frame_valid),
      .busy(busy), .err_count(err_count)
   );

   serial_parity_rx #(.DATA_BITS(8), .ODD_PARITY(1'b1)) u_odd (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .data_out(o_data_out), .parity_err(o_parity_err), .frame_valid(o_frame_valid),
      .busy(o_busy), .err_count(o_err_count)
   );

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       po;
      logic [7:0] ec;
   } exp_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   n_push  = 0;
   int   n_pulse = 0;
   int   cyc_n   = 0;
   int   last_pulse = 0;
   int   prev_pulse = 0;
   int   exp_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every frame_valid pulse must match the oldest entry.
   always @(negedge clk) begin
      cyc_n++;
      if (frame_valid || o_frame_valid) begin
         exp_t e;
         n_pulse++;
         prev_pulse = last_pulse;
         last_pulse = cyc_n;
         if (sb.size() == 0) begin
            chk("unexpected_frame_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("fv_even", {31'd0, frame_valid}, 32'd1);
            chk("fv_odd", {31'd0, o_frame_valid}, 32'd1);
            chk("data_out", {24'd0, data_out}, {24'd0, e.d});
            chk("data_out_odd", {24'd0, o_data_out}, {24'd0, e.d});
            chk("parity_err_even", {31'd0, parity_err}, {31'd0, e.pe});
            chk("parity_err_odd", {31'd0, o_parity_err}, {31'd0, e.po});
            chk("err_count", {24'd0, err_count}, {24'd0, e.ec});
         end
      end
   end

   task automatic cyc(input logic v, input logic s, input logic b);
      bit_valid = v;
      sof       = s;
      bit_in    = b;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic p);
      exp_t e;
      e.d  = d;
      e.pe = (^d) ^ p;
      e.po = (^d) ^ p ^ 1'b1;
      if (CNT_EN && e.pe && exp_err != 255) exp_err++;
      e.ec = 8'(exp_err);
      sb.push_back(e);
      n_push++;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p);
      cyc(1'b1, 1'b1, d[0]);
      chk("busy_after_sof", {31'd0, busy}, 32'd1);
      for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, d[i]);
      push(d, p);
      cyc(1'b1, 1'b0, p);
      chk("busy_after_parity", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
      chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
      chk({tag, "_frame_valid"}, {31'd0, frame_valid}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bit_valid = 1'b0;
      sof = 1'b0;
      bit_in = 1'b0;
      #1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk_zero("reset");
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // Good and bad parity frames
      send_frame(8'hA5, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      send_frame(8'h07, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Aborted frame with idle gaps, then a clean frame with mid-frame gaps
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      repeat (5) cyc(1'b0, 1'b0, 1'b1);
      chk("abort_busy", {31'd0, busy}, 32'd1);
      chk("abort_data_hold", {24'd0, data_out}, 32'h07);
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) begin
         logic [7:0] w;
         w = 8'h3C;
         cyc(1'b1, 1'b0, w[i]);
         if (i == 4) repeat (3) cyc(1'b0, 1'b0, 1'b1);
      end
      chk("abort_no_early_fv", {24'd0, data_out}, 32'h07);
      push(8'h3C, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Back-to-back frames
      send_frame(8'h01, 1'b1);
      send_frame(8'hFF, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("b2b_spacing", 32'(last_pulse - prev_pulse), 32'd9);

      // Reset mid-frame, then unqualified bits in IDLE
      cyc(1'b1, 1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b1);
      chk_zero("mid_reset");
      rst = 1'b0;
      exp_err = 0;
      repeat (9) cyc(1'b1, 1'b0, 1'b1);
      chk_zero("idle_no_sof");
      send_frame(8'h5A, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // Error counter saturation
      repeat (300) send_frame(8'h07, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("err_count_sat", {24'd0, err_count}, CNT_EN ? 32'd255 : 32'd0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      chk_zero("final_reset");
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("pulse_count", 32'(n_pulse), 32'(n_push));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_parity_rx.md
# serial_parity_rx

Bit-serial receiver and parity checker: accepts one data bit per qualified clock, LSB first, assembles a DATA_BITS-wide word, then checks a trailing parity bit by XOR accumulation. It is the checking end of the team's XOR-based parity generator path. It sits between a serial bit source and word-level logic, presenting each completed word with a one-cycle valid pulse and an error flag.

## Interface

- DATA_BITS, 8, data bits per frame (1..32).
- ODD_PARITY, 0, 0 = even parity (total ones, including the parity bit, is even); 1 = odd parity.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data/parity bit.
- bit_valid  input  1  bit_in is qualified this cycle.
- sof  input  1  start of frame; only meaningful with bit_valid=1; marks bit_in as data bit 0.
- data_out  output  DATA_BITS  last completed word, with bit 0 as the first bit received.
- parity_err  output  1  parity result for data_out (1 = mismatch).
- frame_valid  output  1  one-cycle pulse when data_out/parity_err update.
- busy  output  1  a frame is in progress (state != IDLE).
- err_count  output  8  count of parity errors (see Configuration).

## Operation

- States: IDLE, DATA, PARITY.
- IDLE:
  - bit_valid=1 with sof=1 loads bit_in into shift bit 0 and seeds the accumulator with bit_in.
  - Bit counter is set to 1. Next state is DATA, or PARITY if DATA_BITS=1.
  - bit_valid=1 with sof=0 is ignored.
- DATA:
  - Each bit_valid=1 with sof=0 stores bit_in at the position given by the counter, XORs it into the accumulator and increments the counter.
  - When the counter reaches DATA_BITS, next state is PARITY.
  - bit_valid=0 holds all state; gaps of any length are allowed.
- PARITY:
  - bit_valid=1 with sof=0 samples the parity bit.
  - On that edge: data_out is loaded with the assembled word; parity_err = acc ^ bit_in ^ ODD_PARITY; frame_valid=1; state goes to IDLE.
- sof=1 with bit_valid=1 while in DATA or PARITY aborts the current frame:
  - No frame_valid, and data_out/parity_err are unchanged.
  - The bit is taken as data bit 0 of a new frame (same action as sof in IDLE).
- data_out and parity_err hold their values until the next completed frame.
- Shift register and accumulator are internal; partial words are never visible on data_out.

## Timing

- Reset values: data_out=0, parity_err=0, frame_valid=0, busy=0, err_count=0, state=IDLE, counter=0, accumulator=0.
- rst mid-frame discards the partial frame; the next frame must begin with sof.
- Latency: data_out, parity_err and frame_valid update on the same edge that samples the parity bit. frame_valid is high for exactly the following cycle.
- Minimum frame: DATA_BITS+1 qualified cycles.
- Back-to-back frames are supported: sof on the cycle right after the parity bit is accepted, with no dead cycle. frame_valid may be high in the same cycle as the new frame's first bit.
- busy goes high on the edge accepting a sof bit and low on the edge accepting the parity bit.
- rst has priority over all inputs.

## Configuration

- PARITY_ERR_COUNT_EN defined:
  - err_count increments by 1 on every edge that sets frame_valid with parity_err=1.
  - It saturates at 255 and clears only on rst.
- PARITY_ERR_COUNT_EN undefined:
  - err_count is tied to 0 and no counter logic is built.
  - All other behaviour is identical.

## Test plan

- DATA_BITS=8, even parity: sof+bits of 0xA5 LSB first, then parity 0 -> frame_valid pulse, data_out=0xA5, parity_err=0, err_count=0.
- Even parity: frame 0x07 with parity 0 -> data_out=0x07, parity_err=1, err_count=1 (macro on) / 0 (macro off). ODD_PARITY=1 with the same frame -> parity_err=0.
- Abort and gaps: 3 bits of a frame, idle gaps of 5 cycles, then sof+0x3C with parity 0 -> exactly one frame_valid, data_out=0x3C, parity_err=0.
- Back-to-back frames: 0x01/parity 1 then 0xFF/parity 0 with no gap -> two frame_valid pulses 9 cycles apart, both with parity_err=0.
- Reset mid-frame: rst after 4 bits, then a full frame 0x5A/parity 0 -> all outputs 0 during/after rst; then data_out=0x5A, parity_err=0. bit_valid without sof in IDLE -> no effect.
- Saturation (macro on): 300 frames with bad parity -> err_count stops at 255; rst -> 0.
